// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package mem_bus_arbiter_pkg;

  // Default bus widths, matching the core's instruction-address and register buses
  localparam int INST_ADDR_W = 32;
  localparam int REG_W       = 32;

  // Arbiter FSM encodings
  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbGntI = 2'd1,
    ArbGntD = 2'd2
  } arb_state_t;

  // Completion/error signal levels
  localparam logic ACK_ON  = 1'b1;
  localparam logic ACK_OFF = 1'b0;
  localparam logic ERR_ON  = 1'b1;
  localparam logic ERR_OFF = 1'b0;

  // Width of a counter that must hold the values 0 .. n-1
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_bus_arb_pick.sv
// Winner select for the next slave grant: data first unless instruction has waited too long.
// Latency: combinational.
// Backpressure: none; the caller only samples the pick while idle.
module mem_bus_arb_pick
  import mem_bus_arbiter_pkg::*;
#(
  parameter int D_MAX_CONSEC = 4,
  parameter int DC_W         = 3
) (
  input  logic            i_req,
  input  logic            d_req,
  input  logic [DC_W-1:0] d_cnt,
  output logic            pick_i,
  output logic            pick_d
);

  logic d_limit;

  // Data wins unless it has used up its run of back-to-back grants while a fetch waits
  always_comb begin
    d_limit = i_req && (d_cnt == DC_W'(D_MAX_CONSEC));
    pick_d  = d_req && !d_limit;
    pick_i  = i_req && !pick_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported slave between the fetch and data masters, one transaction at a time.
// Latency: request in idle -> m_req next cycle -> ack in the m_ack cycle; one idle bubble between grants.
// Backpressure: masters hold req until ack; stall requests freeze IF/MEM; slave silence ends in a timeout error.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = INST_ADDR_W,
  parameter int DATA_W       = REG_W,
  parameter int TIMEOUT      = 255,
  parameter int D_MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic              i_err,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_sel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_sel,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  localparam int TO_W = cnt_w(TIMEOUT);
  localparam int DC_W = cnt_w(D_MAX_CONSEC + 1);

  arb_state_t      state;
  logic [TO_W-1:0] cnt;
  logic [DC_W-1:0] d_cnt;
  logic            pick_i;
  logic            pick_d;
  logic            last_cyc;
  logic            gnt_done;

  mem_bus_arb_pick #(
    .D_MAX_CONSEC(D_MAX_CONSEC),
    .DC_W        (DC_W)
  ) u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .d_cnt (d_cnt),
    .pick_i(pick_i),
    .pick_d(pick_d)
  );

  // Completion is the slave ack, or the last allowed grant cycle; a late ack still beats the timeout
  always_comb begin
    last_cyc = (cnt == TO_W'(TIMEOUT - 1));
    gnt_done = (state != ArbIdle) && (m_ack || last_cyc);
  end

  // Grant FSM, timeout counter, data-run counter and the registered slave request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ArbIdle;
      cnt     <= '0;
      d_cnt   <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_sel   <= 4'b0000;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      case (state)
        ArbIdle: begin
          if (pick_d) begin
            state   <= ArbGntD;
            cnt     <= '0;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_sel   <= d_sel;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (d_cnt != DC_W'(D_MAX_CONSEC)) begin
              d_cnt <= d_cnt + 1'b1;
            end
          end else if (pick_i) begin
            // Fetches are full-word reads
            state   <= ArbGntI;
            cnt     <= '0;
            d_cnt   <= '0;
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_sel   <= 4'b1111;
            m_addr  <= i_addr;
            m_wdata <= '0;
          end
        end
        ArbGntI, ArbGntD: begin
          if (gnt_done) begin
            state <= ArbIdle;
            m_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ArbIdle;
          m_req <= 1'b0;
        end
      endcase
    end
  end

  // Per-master completion strobes; read data is forced to zero except on a real slave ack
  always_comb begin
    i_ack   = ACK_OFF;
    i_err   = ERR_OFF;
    i_rdata = '0;
    d_ack   = ACK_OFF;
    d_err   = ERR_OFF;
    d_rdata = '0;
    if (state == ArbGntI) begin
      if (m_ack || last_cyc) i_ack = ACK_ON;
      if (!m_ack && last_cyc) i_err = ERR_ON;
      if (m_ack) i_rdata = m_rdata;
    end
    if (state == ArbGntD) begin
      if (m_ack || last_cyc) d_ack = ACK_ON;
      if (!m_ack && last_cyc) d_err = ERR_ON;
      if (m_ack) d_rdata = m_rdata;
    end
    stallreq_if  = i_req && !i_ack;
    stallreq_mem = d_req && !d_ack;
  end

endmodule
